packet_injector: RTL and testbench

PACKET_INJECTOR -- requirements
Module: packet_injector

---
 rtl/packet_injector_pkg.sv | 40 ++++
 rtl/packet_injector_sync2.sv | 31 +++
 rtl/packet_injector.sv | 149 ++++++++++++++
 tb/tb_packet_injector.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/packet_injector_pkg.sv
// -----------------------------------------------------------------------------
// packet_injector_pkg
// Purpose : shared definitions for the packet injector: packet field layout,
//           the "valid entry" tag value and the controller state encoding.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package packet_injector_pkg;

   // Packet layout: [37:35] TAG, [34:27] GEN, [26:20] DST, [19:16] FLG, [15:0] DATA
   localparam int PKT_W    = 38;
   localparam int TAG_LSB  = 35;
   localparam int TAG_W    = 3;
   localparam int GEN_LSB  = 27;
   localparam int GEN_W    = 8;
   localparam int DST_LSB  = 20;
   localparam int DST_W    = 7;
   localparam int FLG_LSB  = 16;
   localparam int FLG_W    = 4;
   localparam int DATA_LSB = 0;
   localparam int DATA_W   = 16;

   // Any other tag marks the end of the upstream program
   localparam logic [TAG_W-1:0] TAG_VALID = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_SETTLE = 3'd2,
      S_CHECK  = 3'd3,
      S_REQ    = 3'd4,
      S_REL    = 3'd5,
      S_DONE   = 3'd6,
      S_ERR    = 3'd7
   } state_t;

   function automatic logic [TAG_W-1:0] pkt_tag(input logic [PKT_W-1:0] pkt);
      return pkt[TAG_LSB +: TAG_W];
   endfunction

endpackage

// File: rtl/packet_injector_sync2.sv
// -----------------------------------------------------------------------------
// packet_injector_sync2
// Purpose : two-flop synchronizer for a single asynchronous level.
// Ports   : i_clk   - destination clock
//           i_rst_n - asynchronous active-low reset (both flops clear to 0)
//           i_d     - asynchronous input level
//           o_q     - synchronized level, two clocks of latency
// -----------------------------------------------------------------------------
module packet_injector_sync2 (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/packet_injector.sv
// -----------------------------------------------------------------------------
// packet_injector
// Purpose : fetches packets from an upstream stage one at a time and pushes
//           each to a downstream consumer over a four-phase REQ/ACK handshake.
//           A run ends on an end-of-program tag, after MAX_PKTS packets, or
//           with an error when the consumer does not respond in time.
// Ports   : i_clk      - clock, rising edge
//           i_rst_n    - asynchronous active-low reset
//           i_start    - run request, honoured only in IDLE/DONE/ERR
//           i_pkt_in   - packet presented by the upstream fetch stage
//           o_fetch    - one-cycle pulse advancing the upstream stage
//           o_pkt_out  - registered packet to downstream
//           o_req_out  - four-phase request to downstream
//           i_ack_in   - four-phase acknowledge (asynchronous)
//           o_busy     - run in progress
//           o_done     - run finished normally
//           o_err      - run aborted on handshake timeout
//           o_cnt      - packets fully handshaken in the current run
// -----------------------------------------------------------------------------
module packet_injector
   import packet_injector_pkg::*;
#(
   parameter int MAX_PKTS    = 20,
   parameter int SETTLE_CYC  = 1,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [PKT_W-1:0] i_pkt_in,
   output logic             o_fetch,
   output logic [PKT_W-1:0] o_pkt_out,
   output logic             o_req_out,
   input  logic             i_ack_in,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err,
   output logic [4:0]       o_cnt
);

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
   localparam logic [7:0] TO_LAST     = 8'(ACK_TIMEOUT - 1);
   localparam logic [4:0] CNT_MAX     = 5'(MAX_PKTS);

   state_t             r_state;
   state_t             w_state_next;
   logic [7:0]         r_tmr;
   logic [4:0]         r_cnt;
   logic [4:0]         w_cnt_plus1;
   logic [PKT_W-1:0]   r_pkt;
   logic               r_fetch;
   logic               r_req;
   logic               r_busy;
   logic               r_done;
   logic               r_err;
   logic               w_ack_s;
   logic               w_load_pkt;
   logic               w_cnt_clr;
   logic               w_cnt_inc;

   packet_injector_sync2 u_ack_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_ack_in),
      .o_q     (w_ack_s)
   );

   // Saturating increment so CNT can never wrap past MAX_PKTS
   assign w_cnt_plus1 = (r_cnt >= CNT_MAX) ? r_cnt : r_cnt + 5'd1;

   always_comb begin
      w_state_next = r_state;
      w_load_pkt   = 1'b0;
      w_cnt_clr    = 1'b0;
      w_cnt_inc    = 1'b0;
      case (r_state)
         S_IDLE, S_DONE, S_ERR: begin
            if (i_start) begin
               w_state_next = S_FETCH;
               w_cnt_clr    = 1'b1;
            end
         end
         S_FETCH:  w_state_next = S_SETTLE;
         S_SETTLE: begin
            if (r_tmr == SETTLE_LAST) w_state_next = S_CHECK;
         end
         S_CHECK: begin
            if (pkt_tag(i_pkt_in) != TAG_VALID) begin
               w_state_next = S_DONE;
            end else begin
               w_load_pkt   = 1'b1;
               w_state_next = S_REQ;
            end
         end
         S_REQ: begin
            // Level-sensitive: an ACK already high advances at once
            if (w_ack_s)               w_state_next = S_REL;
            else if (r_tmr == TO_LAST) w_state_next = S_ERR;
         end
         S_REL: begin
            if (!w_ack_s) begin
               w_cnt_inc    = 1'b1;
               w_state_next = (w_cnt_plus1 == CNT_MAX) ? S_DONE : S_FETCH;
            end else if (r_tmr == TO_LAST) begin
               w_state_next = S_ERR;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_tmr   <= 8'd0;
         r_cnt   <= 5'd0;
         r_pkt   <= '0;
         r_fetch <= 1'b0;
         r_req   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         // One shared timer: cleared on every state entry, so it measures
         // time spent in SETTLE, REQ and REL alike; saturates while parked.
         if (w_state_next != r_state) r_tmr <= 8'd0;
         else if (r_tmr != 8'hFF)     r_tmr <= r_tmr + 8'd1;
         if (w_cnt_clr)      r_cnt <= 5'd0;
         else if (w_cnt_inc) r_cnt <= w_cnt_plus1;
         if (w_load_pkt) r_pkt <= i_pkt_in;
         // Outputs registered from the next state so they are glitch-free
         r_fetch <= (w_state_next == S_FETCH);
         r_req   <= (w_state_next == S_REQ);
         r_busy  <= !(w_state_next inside {S_IDLE, S_DONE, S_ERR});
         r_done  <= (w_state_next == S_DONE);
         r_err   <= (w_state_next == S_ERR);
      end
   end

   assign o_fetch   = r_fetch;
   assign o_pkt_out = r_pkt;
   assign o_req_out = r_req;
   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_err     = r_err;
   assign o_cnt     = r_cnt;

endmodule

// File: tb/tb_packet_injector.sv
// -----------------------------------------------------------------------------
// tb_packet_injector
// Purpose : directed self-checking bench. Two injector instances share the
//           clock: u_dut1 (MAX_PKTS=20, SETTLE_CYC=1, ACK_TIMEOUT=10) runs the
//           end-of-program, busy-START, timeout and reset scenarios;
//           u_dut2 (MAX_PKTS=2, SETTLE_CYC=3) runs the forced-stop scenario.
//           Each has its own upstream model and an ACK responder whose edges
//           land at non-integer offsets from the clock.
// -----------------------------------------------------------------------------
module tb_packet_injector;
   import packet_injector_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n1 = 1'b0, rst_n2 = 1'b0;
   logic             start1 = 1'b0, start2 = 1'b0;
   logic             ack1 = 1'b0, ack2 = 1'b0;
   logic             resp_en1 = 1'b1, resp_en2 = 1'b1;
   logic [PKT_W-1:0] pkt_in1, pkt_in2, pkt_out1, pkt_out2;
   logic             fetch1, fetch2, req1, req2;
   logic             busy1, busy2, done1, done2, err1, err2;
   logic [4:0]       cnt1, cnt2;

   packet_injector #(.MAX_PKTS(20), .SETTLE_CYC(1), .ACK_TIMEOUT(10)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n1), .i_start(start1), .i_pkt_in(pkt_in1),
      .o_fetch(fetch1), .o_pkt_out(pkt_out1), .o_req_out(req1), .i_ack_in(ack1),
      .o_busy(busy1), .o_done(done1), .o_err(err1), .o_cnt(cnt1));

   packet_injector #(.MAX_PKTS(2), .SETTLE_CYC(3), .ACK_TIMEOUT(255)) u_dut2 (
      .i_clk(clk), .i_rst_n(rst_n2), .i_start(start2), .i_pkt_in(pkt_in2),
      .o_fetch(fetch2), .o_pkt_out(pkt_out2), .o_req_out(req2), .i_ack_in(ack2),
      .o_busy(busy2), .o_done(done2), .o_err(err2), .o_cnt(cnt2));

   // ---------------- upstream models ----------------
   logic [PKT_W-1:0] mem1 [0:7];
   logic [PKT_W-1:0] mem2 [0:7];
   int ptr1, ptr2;

   function automatic logic [PKT_W-1:0] mk(input logic [2:0] tag, input int idx,
                                           input logic [15:0] data);
      return {tag, 8'(8'hA0 + idx), 7'(7'h10 + idx), 4'h5, data};
   endfunction

   initial begin
      logic [15:0] d1 [0:3];
      d1[0] = 16'd3; d1[1] = 16'd1; d1[2] = 16'd2; d1[3] = 16'd3;
      for (int i = 0; i < 8; i++) begin
         mem1[i] = (i < 4) ? mk(3'b111, i, d1[i & 3]) : mk(3'b000, i, 16'hDEAD);
         mem2[i] = mk(3'b111, i + 8, 16'(100 + i));
      end
   end

   // Each FETCH pulse presents the next entry; entry 0 after the first pulse
   always @(posedge clk or negedge rst_n1)
      if (!rst_n1) ptr1 <= 0; else if (fetch1) ptr1 <= ptr1 + 1;
   always @(posedge clk or negedge rst_n2)
      if (!rst_n2) ptr2 <= 0; else if (fetch2) ptr2 <= ptr2 + 1;
   assign pkt_in1 = (ptr1 == 0) ? '0 : mem1[3'(ptr1 - 1)];
   assign pkt_in2 = (ptr2 == 0) ? '0 : mem2[3'(ptr2 - 1)];

   // ---------------- ACK responders (off-grid edges) ----------------
   always begin
      @(posedge clk);
      if (!resp_en1)           ack1 = 1'b0;
      else if (req1 && !ack1)  begin @(posedge clk); #3 ack1 = 1'b1; end
      else if (!req1 && ack1)  begin @(posedge clk); #7 ack1 = 1'b0; end
   end
   always begin
      @(posedge clk);
      if (!resp_en2)           ack2 = 1'b0;
      else if (req2 && !ack2)  begin @(posedge clk); #4 ack2 = 1'b1; end
      else if (!req2 && ack2)  begin @(posedge clk); #6 ack2 = 1'b0; end
   end

   // ---------------- monitors ----------------
   int               nf1 = 0, nf2 = 0, stab_bad1 = 0;
   logic             req1_d = 1'b0;
   logic [PKT_W-1:0] held1 = '0;
   logic [PKT_W-1:0] cap1 [$];

   always @(negedge clk) begin
      if (fetch1) nf1++;
      if (fetch2) nf2++;
      if (req1 && !req1_d) begin
         cap1.push_back(pkt_out1);
         held1 = pkt_out1;
      end else if (req1 && pkt_out1 !== held1) begin
         stab_bad1++;
      end
      req1_d = req1;
   end

   // ---------------- checking ----------------
   int n_vec = 0, n_miss = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic pulse_start(input int which);
      if (which == 1) start1 = 1'b1; else start2 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      start2 = 1'b0;
   endtask

   // sel: 0 = req1, 1 = done1, 2 = done2
   task automatic wait_for(input int sel, input int maxc, input string tag);
      bit hit = 1'b0;
      for (int i = 0; i < maxc && !hit; i++) begin
         @(negedge clk);
         case (sel)
            0:       hit = req1;
            1:       hit = done1;
            default: hit = done2;
         endcase
      end
      check_val(tag, 64'(hit), 64'd1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int f0, c0;

      // ---- reset state ----
      repeat (3) @(negedge clk);
      check_val("rst_fetch", 64'(fetch1), 64'd0);
      check_val("rst_req",   64'(req1),   64'd0);
      check_val("rst_pkt",   64'(pkt_out1), 64'd0);
      check_val("rst_cnt",   64'(cnt1),   64'd0);
      check_val("rst_busy",  64'(busy1),  64'd0);
      check_val("rst_done",  64'(done1),  64'd0);
      check_val("rst_err",   64'(err1),   64'd0);
      rst_n1 = 1'b1;
      rst_n2 = 1'b1;
      @(negedge clk);

      // ---- end-of-program run with a START pulsed mid-handshake ----
      f0 = nf1;
      pulse_start(1);
      wait_for(0, 20, "wait_req_run1");
      c0 = int'(cnt1);
      pulse_start(1);
      check_val("busy_start_busy", 64'(busy1), 64'd1);
      check_val("busy_start_cnt",  64'(cnt1),  64'(c0));
      check_val("busy_start_req",  64'(req1),  64'd1);
      wait_for(1, 500, "wait_done_run1");
      check_val("run1_cnt",    64'(cnt1), 64'd4);
      check_val("run1_done",   64'(done1), 64'd1);
      check_val("run1_err",    64'(err1), 64'd0);
      check_val("run1_busy",   64'(busy1), 64'd0);
      check_val("run1_fetches", 64'(nf1 - f0), 64'd5);
      check_val("run1_npkts",  64'(cap1.size()), 64'd4);
      for (int i = 0; i < 4; i++)
         check_val($sformatf("run1_pkt%0d", i),
                   (i < cap1.size()) ? 64'(cap1[i]) : 64'd0, 64'(mem1[i]));
      check_val("run1_pkt_stable", 64'(stab_bad1), 64'd0);

      // ---- restart from DONE: CNT/DONE cleared, next entry ends the run ----
      f0 = nf1;
      pulse_start(1);
      check_val("restart_done", 64'(done1), 64'd0);
      check_val("restart_cnt",  64'(cnt1),  64'd0);
      check_val("restart_busy", 64'(busy1), 64'd1);
      wait_for(1, 50, "wait_done_restart");
      check_val("restart_cnt_end", 64'(cnt1), 64'd0);
      check_val("restart_fetches", 64'(nf1 - f0), 64'd1);

      // ---- ACK held low: timeout after 10 cycles in REQ ----
      rst_n1 = 1'b0;
      resp_en1 = 1'b0;
      @(negedge clk);
      rst_n1 = 1'b1;
      @(negedge clk);
      pulse_start(1);
      wait_for(0, 20, "wait_req_timeout");
      repeat (9) @(negedge clk);
      check_val("to_err_early", 64'(err1), 64'd0);
      @(negedge clk);
      check_val("to_err",  64'(err1),  64'd1);
      check_val("to_req",  64'(req1),  64'd0);
      check_val("to_busy", 64'(busy1), 64'd0);
      check_val("to_cnt",  64'(cnt1),  64'd0);

      // ---- asynchronous reset while REQ_OUT is high ----
      rst_n1 = 1'b0;
      @(negedge clk);
      rst_n1 = 1'b1;
      @(negedge clk);
      pulse_start(1);
      wait_for(0, 20, "wait_req_reset");
      #2 rst_n1 = 1'b0;
      #1;
      check_val("arst_req",   64'(req1),     64'd0);
      check_val("arst_fetch", 64'(fetch1),   64'd0);
      check_val("arst_pkt",   64'(pkt_out1), 64'd0);
      check_val("arst_busy",  64'(busy1),    64'd0);
      check_val("arst_done",  64'(done1),    64'd0);
      check_val("arst_err",   64'(err1),     64'd0);
      check_val("arst_cnt",   64'(cnt1),     64'd0);
      @(negedge clk);
      rst_n1 = 1'b1;
      resp_en1 = 1'b1;
      @(negedge clk);
      f0 = nf1;
      pulse_start(1);
      check_val("rerun_busy", 64'(busy1), 64'd1);
      check_val("rerun_cnt0", 64'(cnt1),  64'd0);
      wait_for(1, 500, "wait_done_rerun");
      check_val("rerun_cnt",     64'(cnt1), 64'd4);
      check_val("rerun_fetches", 64'(nf1 - f0), 64'd5);

      // ---- forced stop at MAX_PKTS=2 ----
      f0 = nf2;
      pulse_start(2);
      wait_for(2, 500, "wait_done_max");
      check_val("max_cnt",     64'(cnt2), 64'd2);
      check_val("max_done",    64'(done2), 64'd1);
      check_val("max_err",     64'(err2), 64'd0);
      check_val("max_fetches", 64'(nf2 - f0), 64'd2);
      check_val("max_pkt_out", 64'(pkt_out2), 64'(mem2[1]));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
